// File: rtl/uart_pkg.sv
// Shared types and sample-point helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int half_pt(input int clks);
    return clks / 2;
  endfunction

  function automatic int offs_pt(input int clks);
    return clks / 16;
  endfunction

  function automatic int s0_pt(input int clks);
    return half_pt(clks) - offs_pt(clks);
  endfunction

  function automatic int s2_pt(input int clks);
    return half_pt(clks) + offs_pt(clks);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, bit-time counter and 3-point majority vote for one bit cell.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 192,
  parameter int SYNC_STAGES  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic run,
  input  logic last,
  output logic line,
  output logic bit_done,
  output logic bit_val
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] P0   = CW'(s0_pt(CLKS_PER_BIT));
  localparam logic [CW-1:0] P1   = CW'(half_pt(CLKS_PER_BIT));
  localparam logic [CW-1:0] P2   = CW'(s2_pt(CLKS_PER_BIT));
  localparam logic [CW-1:0] P2N  = CW'(s2_pt(CLKS_PER_BIT) + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [2:0]             smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], serial_in};
  end

  assign line = sync[SYNC_STAGES-1];

  // The final stop bit ends early so the next start edge is caught on time.
  assign bit_done = run && (cnt == (last ? P2N : LAST));
  assign bit_val  = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      smp <= '1;
    end else begin
      if (!run || bit_done) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
      if (run && cnt == P0) smp[0] <= line;
      if (run && cnt == P1) smp[1] <= line;
      if (run && cnt == P2) smp[2] <= line;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: frame FSM, data shifter and a one-deep valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 192,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  state_t               state, next;
  logic                 line, bit_done, bit_val, last_stop, done;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q, frm_q;

  assign last_stop = (state == ST_STOP) && ((STOP_BITS == 1) || stop_idx);
  assign done      = last_stop && bit_done;
  assign busy      = (state != ST_IDLE);

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .serial_in(serial_in),
    .run      (busy),
    .last     (last_stop),
    .line     (line),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   if (!line) next = ST_START;
      ST_START:  if (bit_done) next = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_done && bit_idx == 4'(DATA_BITS - 1))
                   next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) next = ST_STOP;
      ST_STOP:   if (done) next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  // LSB-first line order: shifting in from the top leaves bit 0 in the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_q    <= 1'b0;
      frm_q    <= 1'b0;
    end else if (state == ST_IDLE) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_q    <= 1'b0;
      frm_q    <= 1'b0;
    end else if (bit_done) begin
      case (state)
        ST_DATA: begin
          shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        ST_PARITY: par_q <= ((^shreg) ^ bit_val) != (PARITY == PARITY_ODD);
        ST_STOP: begin
          frm_q    <= frm_q | ~bit_val;
          stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data    <= shreg;
          frame_err  <= frm_q | ~bit_val;
          parity_err <= par_q;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Four receiver configurations driven with directed and random frames, checked against a frame-level model.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst, ser, rdy;
  logic [3:0] vld, fe, pe, ovr, bsy;
  logic [7:0] rxd_a, rxd_p;
  logic [6:0] rxd_b;
  logic [8:0] rxd_o;
  logic [3:0][8:0] rxd;
  assign rxd = {rxd_o, {2'b0, rxd_b}, {1'b0, rxd_p}, {1'b0, rxd_a}};

  uart_rx_param dut_a (
    .clk(clk), .rst(rst[0]), .serial_in(ser[0]), .rx_data(rxd_a), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_param #(.PARITY(1)) dut_p (
    .clk(clk), .rst(rst[1]), .serial_in(ser[1]), .rx_data(rxd_p), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst[2]), .serial_in(ser[2]), .rx_data(rxd_b), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ovr[2]), .busy(bsy[2]));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(9), .PARITY(2)) dut_o (
    .clk(clk), .rst(rst[3]), .serial_in(ser[3]), .rx_data(rxd_o), .rx_valid(vld[3]),
    .rx_ready(rdy[3]), .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ovr[3]), .busy(bsy[3]));

  function automatic int cpb(input int d); return (d < 2) ? 192 : 16; endfunction
  function automatic int db(input int d);  return (d == 2) ? 7 : (d == 3) ? 9 : 8; endfunction
  function automatic int pm(input int d);  return (d == 1) ? 1 : (d == 3) ? 2 : 0; endfunction
  function automatic int sb(input int d);  return (d == 2) ? 2 : 1; endfunction

  int vectors = 0, errors = 0;
  logic [10:0] exp_mem [4][64];
  int wr [4];
  int rd [4];
  int ovr_cnt [4];
  bit [3:0] ovr_ok = '0;
  bit [3:0] rand_rdy = '0;
  bit stim_done = 1'b0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, want %0h", name, d, act, expv);
    end
  endtask

  // Scoreboard: every accepted character must be the oldest one the model expects.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (ovr[d]) begin
        if (ovr_ok[d]) ovr_cnt[d]++;
        else begin
          vectors++; errors++;
          $display("FAIL overrun_unexpected dut%0d: got 1, want 0", d);
        end
      end
      if (vld[d] && rdy[d]) begin
        if (rd[d] == wr[d]) begin
          vectors++; errors++;
          $display("FAIL spurious_char dut%0d: got data %0h, want none", d, rxd[d]);
        end else begin
          chk("rx_char", d, 32'({fe[d], pe[d], rxd[d]}), 32'(exp_mem[d][rd[d] % 64]));
          rd[d]++;
        end
      end
    end
  end

  // Frame model: line bits LSB first and the {frame_err, parity_err, data} they must yield.
  function automatic void build(input int d, input logic [8:0] data, input bit pflip, input bit stop0,
                                output logic [15:0] bits, output int n, output logic [10:0] e);
    logic [8:0] m;
    m = data & 9'((1 << db(d)) - 1);
    bits = '0;
    n = 1;
    for (int i = 0; i < db(d); i++) begin bits[n] = m[i]; n++; end
    if (pm(d) != 0) begin
      bits[n] = (^m) ^ (pm(d) == 2) ^ pflip;
      n++;
    end
    for (int i = 0; i < sb(d); i++) begin bits[n] = ~stop0; n++; end
    e = {stop0, pflip && (pm(d) != 0), m};
  endfunction

  // Cycles from the first start-bit edge to the cycle the receiver completes the frame.
  function automatic int done_off(input int d, input int n);
    return 4 + (n - 1) * cpb(d) + cpb(d) / 2 + cpb(d) / 16 + 1;
  endfunction

  task automatic push(input int d, input logic [10:0] e);
    exp_mem[d][wr[d] % 64] = e;
    wr[d]++;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ser[d] = bits[i];
      repeat (cpb(d)) @(posedge clk);
      #1;
    end
    ser[d] = 1'b1;
  endtask

  task automatic frame(input int d, input logic [8:0] data, input bit pflip, input bit stop0, input bit expect_out);
    logic [15:0] bits; int n; logic [10:0] e;
    build(d, data, pflip, stop0, bits, n, e);
    if (expect_out) push(d, e);
    send(d, bits, n);
  endtask

  task automatic rand_frames(input int d, input int nfr);
    bit s0, pf;
    for (int f = 0; f < nfr; f++) begin
      s0 = ($urandom_range(0, 7) == 0);
      pf = (pm(d) != 0) && ($urandom_range(0, 1) == 1);
      frame(d, 9'($urandom), pf, s0, 1'b1);
      idle(s0 ? 2 * cpb(d) : $urandom_range(0, cpb(d)));
    end
  endtask

  task automatic seq_a;
    logic [15:0] bits; int n; logic [10:0] e; int t0;
    // 8N1 0xA5 with exact completion latency and single-cycle valid
    build(0, 9'h0A5, 1'b0, 1'b0, bits, n, e);
    push(0, e);
    fork
      send(0, bits, n);
      begin
        repeat (done_off(0, n)) @(posedge clk);
        @(negedge clk); chk("t1_valid_before", 0, 32'(vld[0]), 0);
        @(negedge clk); chk("t1_valid_rise", 0, 32'(vld[0]), 1);
        chk("t1_data", 0, 32'(rxd[0]), 32'h0A5);
        chk("t1_flags", 0, 32'({fe[0], pe[0]}), 0);
        @(negedge clk); chk("t1_valid_fall", 0, 32'(vld[0]), 0);
      end
    join
    idle(cpb(0));
    // stop bit low, then a break
    frame(0, 9'h03C, 1'b0, 1'b1, 1'b1);
    idle(2 * cpb(0));
    frame(0, 9'h000, 1'b0, 1'b1, 1'b1);
    idle(2 * cpb(0));
    chk("t3_break_data", 0, 32'(rxd[0]), 0);
    chk("t3_break_ferr", 0, 32'(fe[0]), 1);
    // consumer stalled: second character dropped with one overrun pulse
    rdy[0] = 1'b0; ovr_ok[0] = 1'b1; ovr_cnt[0] = 0;
    frame(0, 9'h011, 1'b0, 1'b0, 1'b1);
    idle(cpb(0));
    frame(0, 9'h022, 1'b0, 1'b0, 1'b0);
    idle(cpb(0));
    chk("t4_held_valid", 0, 32'(vld[0]), 1);
    chk("t4_held_data", 0, 32'(rxd[0]), 32'h011);
    chk("t4_overrun_pulses", 0, 32'(ovr_cnt[0]), 1);
    rdy[0] = 1'b1; idle(1); rdy[0] = 1'b0;
    // accept in the completion cycle: new character loads, no overrun
    ovr_cnt[0] = 0;
    frame(0, 9'h011, 1'b0, 1'b0, 1'b1);
    idle(cpb(0));
    build(0, 9'h022, 1'b0, 1'b0, bits, n, e);
    push(0, e);
    fork
      send(0, bits, n);
      begin
        idle(done_off(0, n));
        rdy[0] = 1'b1; idle(1); rdy[0] = 1'b0;
      end
    join
    idle(cpb(0));
    chk("t4b_valid", 0, 32'(vld[0]), 1);
    chk("t4b_data", 0, 32'(rxd[0]), 32'h022);
    chk("t4b_overrun_pulses", 0, 32'(ovr_cnt[0]), 0);
    ovr_ok[0] = 1'b0;
    rdy[0] = 1'b1; idle(4);
    // 40-cycle glitch: false start, back to idle one bit time later
    ser[0] = 1'b0; idle(40); ser[0] = 1'b1;
    @(negedge clk); chk("t5_busy_during", 0, 32'(bsy[0]), 1);
    repeat (cpb(0) - 35) @(posedge clk);
    @(negedge clk); chk("t5_busy_after", 0, 32'(bsy[0]), 0);
    chk("t5_no_valid", 0, 32'(vld[0]), 0);
    idle(cpb(0));
    // reset mid-data
    build(0, 9'h077, 1'b0, 1'b0, bits, n, e);
    fork
      send(0, bits, n);
      begin
        idle(4 * cpb(0));
        rst[0] = 1'b1;
        #1;
        chk("t6_rst_busy", 0, 32'(bsy[0]), 0);
        chk("t6_rst_data", 0, 32'(rxd[0]), 0);
        chk("t6_rst_valid", 0, 32'(vld[0]), 0);
      end
    join
    rst[0] = 1'b0;
    idle(cpb(0));
    frame(0, 9'h05A, 1'b0, 1'b0, 1'b1);
    idle(cpb(0));
    rand_rdy[0] = 1'b1;
    rand_frames(0, 6);
  endtask

  task automatic seq_p;
    frame(1, 9'h003, 1'b1, 1'b0, 1'b1);
    idle(cpb(1));
    chk("t2_perr_data", 1, 32'(rxd[1]), 32'h003);
    chk("t2_perr_flag", 1, 32'(pe[1]), 1);
    frame(1, 9'h003, 1'b0, 1'b0, 1'b1);
    idle(cpb(1));
    chk("t2_pok_flag", 1, 32'(pe[1]), 0);
    rand_rdy[1] = 1'b1;
    rand_frames(1, 5);
  endtask

  task automatic seq_b;
    frame(2, 9'h07F, 1'b0, 1'b0, 1'b1);
    frame(2, 9'h000, 1'b0, 1'b0, 1'b1);
    idle(2 * cpb(2));
    chk("t6_b2b_last", 2, 32'({fe[2], rxd[2]}), 0);
    rand_rdy[2] = 1'b1;
    rand_frames(2, 40);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 4; d++) begin wr[d] = 0; rd[d] = 0; ovr_cnt[d] = 0; end
    rst = '1; ser = '1; rdy = '1;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("reset_outputs", d, 32'({vld[d], fe[d], pe[d], ovr[d], bsy[d], rxd[d]}), 0);
    end
    @(posedge clk); #1;
    rst = '0;
    idle(4);
    fork
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          for (int d = 0; d < 4; d++)
            if (rand_rdy[d]) rdy[d] = ($urandom_range(0, 1) == 1);
        end
      end
      begin
        fork
          seq_a();
          seq_p();
          seq_b();
          begin rand_rdy[3] = 1'b1; rand_frames(3, 40); end
        join
        stim_done = 1'b1;
      end
    join
    rand_rdy = '0; rdy = '1;
    idle(50);
    for (int d = 0; d < 4; d++) begin
      chk("all_delivered", d, 32'(wr[d] - rd[d]), 0);
      chk("final_valid", d, 32'(vld[d]), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
